// File: rtl/synth_pkg.sv
// Shared types and saturating helpers for the synth voice datapath.
package synth_pkg;

    localparam int          ENV_W   = 16;
    localparam logic [15:0] ENV_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[16]) begin
            return ENV_MAX;
        end else begin
            return sum[15:0];
        end
    endfunction

    // Subtract with a lower clamp; a borrow also lands on the floor.
    function automatic logic [15:0] sat_sub_floor(input logic [15:0] a, input logic [15:0] b,
                                                  input logic [15:0] floor_v);
        logic [16:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[16] || (diff[15:0] < floor_v)) begin
            return floor_v;
        end else begin
            return diff[15:0];
        end
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle strobe every TICK_DIV clocks.
module sample_tick_gen #(
    parameter int TICK_DIV = 1042
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count_r;

    assign TICK = (count_r == CNT_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count_r <= '0;
        end else if (TICK) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// One-voice ADSR envelope generator stepped at the sample tick.
// Optional feature: `define ADSR_EXP_RELEASE_EN for an exponential-like release.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 1042
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        KEY,
    input  logic [15:0] ATTACK,
    input  logic [15:0] DECAY,
    input  logic [15:0] SUSTAIN,
    input  logic [15:0] RLEASE,
    output logic [15:0] ENV,
    output logic        ENV_TICK,
    output logic        ACTIVE,
    output logic [2:0]  STATE
);

    logic        tick_s;
    logic        rise_s;
    logic        fall_s;
    logic        key_q_r;
    logic        env_tick_r;
    logic        active_r;
    logic [15:0] env_r;
    logic [15:0] env_nxt_s;
    logic [15:0] rel_env_s;
    env_state_t  state_r;
    env_state_t  state_nxt_s;

    sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (tick_s)
    );

    assign rise_s = KEY & ~key_q_r;
    assign fall_s = ~KEY & key_q_r;

`ifdef ADSR_EXP_RELEASE_EN
    logic [15:0] rel_step_s;
    // Step shrinks with level; the +1 keeps it moving when the product rounds to zero.
    assign rel_step_s = 16'((32'(env_r) * 32'(RLEASE)) >> 16) + 16'd1;
    assign rel_env_s  = sat_sub_floor(env_r, rel_step_s, 16'h0000);
`else
    assign rel_env_s  = (RLEASE == 16'h0000) ? 16'h0000 : sat_sub_floor(env_r, RLEASE, 16'h0000);
`endif

    // Next state and saturated level step; gate edges take priority over tick work.
    always_comb begin
        state_nxt_s = state_r;
        env_nxt_s   = env_r;
        if (rise_s) begin
            state_nxt_s = ENV_ATTACK;
        end else if (fall_s) begin
            if ((state_r == ENV_ATTACK) || (state_r == ENV_DECAY) || (state_r == ENV_SUSTAIN)) begin
                state_nxt_s = ENV_RELEASE;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (tick_s) begin
            case (state_r)
                ENV_ATTACK: begin
                    env_nxt_s = (ATTACK == 16'h0000) ? ENV_MAX : sat_add(env_r, ATTACK);
                    if (env_nxt_s == ENV_MAX) begin
                        state_nxt_s = ENV_DECAY;
                    end else begin
                        state_nxt_s = ENV_ATTACK;
                    end
                end
                ENV_DECAY: begin
                    env_nxt_s = (DECAY == 16'h0000) ? SUSTAIN : sat_sub_floor(env_r, DECAY, SUSTAIN);
                    if (env_nxt_s == SUSTAIN) begin
                        state_nxt_s = ENV_SUSTAIN;
                    end else begin
                        state_nxt_s = ENV_DECAY;
                    end
                end
                ENV_SUSTAIN: begin
                    env_nxt_s = SUSTAIN;
                end
                ENV_RELEASE: begin
                    env_nxt_s = rel_env_s;
                    if (env_nxt_s == 16'h0000) begin
                        state_nxt_s = ENV_IDLE;
                    end else begin
                        state_nxt_s = ENV_RELEASE;
                    end
                end
                ENV_IDLE: begin
                    env_nxt_s = 16'h0000;
                end
                default: begin
                    state_nxt_s = ENV_IDLE;
                    env_nxt_s   = 16'h0000;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, level, gate history and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r    <= ENV_IDLE;
            env_r      <= 16'h0000;
            key_q_r    <= 1'b0;
            env_tick_r <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            env_r      <= env_nxt_s;
            key_q_r    <= KEY;
            env_tick_r <= tick_s;
            active_r   <= (state_nxt_s != ENV_IDLE);
        end
    end

    assign ENV      = env_r;
    assign ENV_TICK = env_tick_r;
    assign ACTIVE   = active_r;
    assign STATE    = state_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with an arithmetic reference model (TICK_DIV=4).
module tb_adsr_envelope;

    localparam int TD = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        KEY = 1'b1;
    logic [15:0] ATTACK = 16'h0000;
    logic [15:0] DECAY = 16'h0000;
    logic [15:0] SUSTAIN = 16'h0000;
    logic [15:0] RLEASE = 16'h0000;
    logic [15:0] ENV;
    logic        ENV_TICK;
    logic        ACTIVE;
    logic [2:0]  STATE;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: phase 0=idle 1=attack 2=decay 3=sustain 4=release
    int m_env = 0;
    int m_phase = 0;
    int m_cnt = 0;
    bit m_keyq = 1'b0;
    bit m_etick = 1'b0;

    adsr_envelope #(.TICK_DIV(TD)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .KEY      (KEY),
        .ATTACK   (ATTACK),
        .DECAY    (DECAY),
        .SUSTAIN  (SUSTAIN),
        .RLEASE   (RLEASE),
        .ENV      (ENV),
        .ENV_TICK (ENV_TICK),
        .ACTIVE   (ACTIVE),
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    function automatic int model_next(int ph, int env, bit rise, bit fall, bit tick,
                                      int a, int d, int s, int r);
        int p;
        int e;
        longint st;
        p = ph;
        e = env;
        if (rise) begin
            p = 1;
        end else if (fall) begin
            if (p >= 1 && p <= 3) p = 4;
        end else if (tick) begin
            if (p == 1) begin
                e = (a == 0) ? 65535 : env + a;
                if (e > 65535) e = 65535;
                if (e == 65535) p = 2;
            end else if (p == 2) begin
                e = (d == 0) ? s : env - d;
                if (e < s) e = s;
                if (e == s) p = 3;
            end else if (p == 3) begin
                e = s;
            end else if (p == 4) begin
`ifdef ADSR_EXP_RELEASE_EN
                st = ((longint'(env) * longint'(r)) >>> 16) + 64'sd1;
                e = env - int'(st);
`else
                e = (r == 0) ? 0 : env - r;
`endif
                if (e < 0) e = 0;
                if (e == 0) p = 0;
            end else begin
                e = 0;
            end
        end
        return p * 65536 + e;
    endfunction

    always @(posedge CLK) begin
        if (!RESET) begin
            m_env   <= 0;
            m_phase <= 0;
            m_cnt   <= 0;
            m_keyq  <= 1'b0;
            m_etick <= 1'b0;
        end else begin
            m_phase <= model_next(m_phase, m_env, KEY && !m_keyq, !KEY && m_keyq, m_cnt == TD - 1,
                                  int'(ATTACK), int'(DECAY), int'(SUSTAIN), int'(RLEASE)) / 65536;
            m_env   <= model_next(m_phase, m_env, KEY && !m_keyq, !KEY && m_keyq, m_cnt == TD - 1,
                                  int'(ATTACK), int'(DECAY), int'(SUSTAIN), int'(RLEASE)) % 65536;
            m_cnt   <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
            m_keyq  <= KEY;
            m_etick <= (m_cnt == TD - 1);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_env", int'(ENV), m_env);
            check("model_env_tick", int'(ENV_TICK), int'(m_etick));
            check("model_state", int'(STATE), m_phase);
            check("model_active", int'(ACTIVE), (m_phase != 0) ? 1 : 0);
        end
    end

    task automatic wait_tick();
        int k;
        k = 0;
        @(negedge CLK);
        while (!ENV_TICK && k < 3 * TD) begin
            @(negedge CLK);
            k++;
        end
        if (!ENV_TICK) begin
            n_checks++;
            n_err++;
            $display("FAIL tick_timeout: got no ENV_TICK expected one within %0d cycles", 3 * TD);
        end
    endtask

    task automatic tick_expect(input string nm, input logic [15:0] e, input int st);
        wait_tick();
        check(nm, int'(ENV), int'(e));
        check({nm, "_state"}, int'(STATE), st);
    endtask

    initial begin
        RESET = 1'b0;
        KEY = 1'b1;
        ATTACK = 16'h4000;
        DECAY = 16'h1000;
        SUSTAIN = 16'h8000;
        RLEASE = 16'h3000;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_env", int'(ENV), 0);
        check("reset_state", int'(STATE), 0);
        check("reset_active", int'(ACTIVE), 0);
        RESET = 1'b1;
        @(negedge CLK);
        check("rise_after_reset", int'(STATE), 1);

        tick_expect("att1", 16'h4000, 1);
        tick_expect("att2", 16'h8000, 1);
        tick_expect("att3", 16'hC000, 1);
        tick_expect("att4", 16'hFFFF, 2);
        for (int i = 1; i <= 7; i++) begin
            tick_expect("decay", 16'hFFFF - 16'(i * 16'h1000), 2);
        end
        tick_expect("decay_sus", 16'h8000, 3);

        SUSTAIN = 16'h6000;
        tick_expect("sus_edit", 16'h6000, 3);
        KEY = 1'b0;
        tick_expect("rel1", 16'h3000, 4);
        KEY = 1'b1;
        tick_expect("retrigger", 16'h7000, 1);
        KEY = 1'b0;
        tick_expect("rel_a", 16'h4000, 4);
        tick_expect("rel_b", 16'h1000, 4);
        tick_expect("rel_idle", 16'h0000, 0);
        check("idle_active", int'(ACTIVE), 0);

        ATTACK = 16'h0000;
        DECAY = 16'h0000;
        SUSTAIN = 16'h1234;
        KEY = 1'b1;
        tick_expect("zero_att", 16'hFFFF, 2);
        tick_expect("zero_dec", 16'h1234, 3);
        RLEASE = 16'h0000;
        KEY = 1'b0;
        tick_expect("zero_rel", 16'h0000, 0);

        KEY = 1'b1;
        tick_expect("full_att", 16'hFFFF, 2);
        SUSTAIN = 16'hFFFF;
        DECAY = 16'h1000;
        tick_expect("sus_at_entry", 16'hFFFF, 3);
        RLEASE = 16'h8000;
        KEY = 1'b0;
        tick_expect("half_rel1", 16'h7FFF, 4);
`ifdef ADSR_EXP_RELEASE_EN
        tick_expect("exp_rel2", 16'h3FFF, 4);
`endif
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("midnote_reset_env", int'(ENV), 0);
        check("midnote_reset_state", int'(STATE), 0);
        check("midnote_reset_active", int'(ACTIVE), 0);
        RESET = 1'b1;
        repeat (6) @(negedge CLK);
        check("quiet_after_reset", int'(STATE), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
